// File: rtl/jc_block.sv
// Jump-control unit for the 16-bit MIPS-style core.
// Decides each cycle whether the PC loads a redirect target (jump, interrupt
// vector or interrupt return) and keeps the single-level interrupt context.
module jc_block #(
  parameter int             AW       = 16,
  parameter logic [AW-1:0]  ISR_ADDR = 16'hF000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] jmp_address_pm,
  input  logic [AW-1:0] current_address,
  input  logic [5:0]    op,
  input  logic [1:0]    flag_ex,
  input  logic          interrupt,
  output logic [AW-1:0] jmp_loc,
  output logic          pc_mux_sel
);

  localparam logic [5:0] OP_RET = 6'h10;
  localparam logic [5:0] OP_JMP = 6'h18;
  localparam logic [5:0] OP_JV  = 6'h1C;
  localparam logic [5:0] OP_JNV = 6'h1D;
  localparam logic [5:0] OP_JZ  = 6'h1E;
  localparam logic [5:0] OP_JNZ = 6'h1F;

  logic [AW-1:0] ret_addr_reg;
  logic          in_isr_reg;
  logic          int_d_reg;

  logic flag_z;
  logic flag_v;
  logic int_edge;
  logic int_accept;
  logic ret_take;
  logic jump_take;

  assign flag_z = flag_ex[1];
  assign flag_v = flag_ex[0];

  // Classify the current cycle: interrupt entry, interrupt return or plain jump.
  always_comb begin
    int_edge   = interrupt & ~int_d_reg;
    int_accept = int_edge & ~in_isr_reg;
    ret_take   = (op == OP_RET) & in_isr_reg;
    jump_take  = 1'b0;
    unique case (op)
      OP_JMP:  jump_take = 1'b1;
      OP_JZ:   jump_take = flag_z;
      OP_JNZ:  jump_take = ~flag_z;
      OP_JV:   jump_take = flag_v;
      OP_JNV:  jump_take = ~flag_v;
      default: jump_take = 1'b0;
    endcase
  end

  // Redirect decision in priority order; same-cycle so the PC mux sees it now.
  always_comb begin
    pc_mux_sel = 1'b0;
    jmp_loc    = jmp_address_pm;
    if (reset) begin
      pc_mux_sel = 1'b0;
      jmp_loc    = '0;
    end else if (int_accept) begin
      pc_mux_sel = 1'b1;
      jmp_loc    = ISR_ADDR;
    end else if (ret_take) begin
      pc_mux_sel = 1'b1;
      jmp_loc    = ret_addr_reg;
    end else if (jump_take) begin
      pc_mux_sel = 1'b1;
      jmp_loc    = jmp_address_pm;
    end
  end

  // Interrupt context: save the resume address on entry, leave ISR on RET.
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_addr_reg <= '0;
      in_isr_reg   <= 1'b0;
      int_d_reg    <= 1'b0;
    end else begin
      int_d_reg <= interrupt;
      if (int_accept) begin
        ret_addr_reg <= current_address;
        in_isr_reg   <= 1'b1;
      end else if (ret_take) begin
        in_isr_reg   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jc_block.sv
// Directed bench for jc_block: a behavioural model of the redirect rules is
// checked against the DUT on every vector, and hand-computed expectations
// attached to the vectors pin the model itself.
module tb_jc_block;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] jmp_address_pm;
  logic [15:0] current_address;
  logic [5:0]  op;
  logic [1:0]  flag_ex;
  logic        interrupt;
  logic [15:0] jmp_loc;
  logic        pc_mux_sel;

  jc_block #(.AW(16), .ISR_ADDR(16'hF000)) dut (
    .clk             (clk),
    .reset           (reset),
    .jmp_address_pm  (jmp_address_pm),
    .current_address (current_address),
    .op              (op),
    .flag_ex         (flag_ex),
    .interrupt       (interrupt),
    .jmp_loc         (jmp_loc),
    .pc_mux_sel      (pc_mux_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        irq;
    logic [5:0]  opc;
    logic [1:0]  flg;
    logic [15:0] pm;
    logic [15:0] cur;
    logic        chk;
    logic        e_sel;
    logic [15:0] e_loc;
  } vec_t;

  vec_t vecs[$];

  int n_vec = 0;
  int n_bad = 0;

  // Model state: what the unit must remember, in plain terms.
  logic [15:0] m_saved_pc;
  logic        m_inside_isr;
  logic        m_irq_last;

  task automatic add(input logic rst, input logic irq, input logic [5:0] opc,
                     input logic [1:0] flg, input logic [15:0] pm, input logic [15:0] cur,
                     input logic chk, input logic e_sel, input logic [15:0] e_loc);
    vec_t v;
    v.rst = rst; v.irq = irq; v.opc = opc; v.flg = flg; v.pm = pm; v.cur = cur;
    v.chk = chk; v.e_sel = e_sel; v.e_loc = e_loc;
    vecs.push_back(v);
  endtask

  function automatic bit branch_condition_met(input logic [5:0] opc, input logic [1:0] flg);
    bit z = flg[1];
    bit v = flg[0];
    if (opc == 6'h18) return 1;
    if (opc == 6'h1E) return z;
    if (opc == 6'h1F) return !z;
    if (opc == 6'h1C) return v;
    if (opc == 6'h1D) return !v;
    return 0;
  endfunction

  task automatic check1(input string name, input int idx, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s vec%0d: got %0b want %0b", name, idx, act, req);
    end
  endtask

  task automatic check16(input string name, input int idx, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s vec%0d: got %h want %h", name, idx, act, req);
    end
  endtask

  initial begin
    logic        want_sel;
    logic [15:0] want_loc;
    bit          fresh_irq;

    // Reset with a JMP present.
    add(1, 0, 6'h18, 2'b00, 16'h0008, 16'h0000, 1, 0, 16'h0000);
    add(1, 0, 6'h18, 2'b00, 16'h0008, 16'h0000, 1, 0, 16'h0000);
    // Unconditional jump and a non-jump.
    add(0, 0, 6'h18, 2'b11, 16'h0008, 16'h0000, 1, 1, 16'h0008);
    add(0, 0, 6'h00, 2'b11, 16'h0008, 16'h0000, 1, 0, 16'h0008);
    // Conditionals.
    add(0, 0, 6'h1E, 2'b00, 16'h0008, 16'h0000, 1, 0, 16'h0008);
    add(0, 0, 6'h1E, 2'b10, 16'h0008, 16'h0000, 1, 1, 16'h0008);
    add(0, 0, 6'h1F, 2'b00, 16'h0008, 16'h0000, 1, 1, 16'h0008);
    add(0, 0, 6'h1F, 2'b10, 16'h0030, 16'h0000, 1, 0, 16'h0030);
    add(0, 0, 6'h1C, 2'b01, 16'h0008, 16'h0000, 1, 1, 16'h0008);
    add(0, 0, 6'h1C, 2'b10, 16'h0040, 16'h0000, 1, 0, 16'h0040);
    add(0, 0, 6'h1D, 2'b01, 16'h0008, 16'h0000, 1, 0, 16'h0008);
    add(0, 0, 6'h1D, 2'b10, 16'h1234, 16'h0000, 1, 1, 16'h1234);
    // Interrupt held 3 cycles, then return.
    add(0, 1, 6'h00, 2'b00, 16'h0008, 16'h0001, 1, 1, 16'hF000);
    add(0, 1, 6'h00, 2'b00, 16'h0008, 16'h0002, 1, 0, 16'h0008);
    add(0, 1, 6'h00, 2'b00, 16'h0008, 16'h0003, 1, 0, 16'h0008);
    add(0, 0, 6'h10, 2'b00, 16'h0008, 16'h0004, 1, 1, 16'h0001);
    add(0, 0, 6'h10, 2'b00, 16'h0008, 16'h0005, 1, 0, 16'h0008);
    // Interrupt beats JMP; jumps work inside ISR; second edge ignored.
    add(0, 1, 6'h18, 2'b00, 16'h0020, 16'h0042, 1, 1, 16'hF000);
    add(0, 0, 6'h18, 2'b00, 16'h0020, 16'h0043, 1, 1, 16'h0020);
    add(0, 1, 6'h00, 2'b00, 16'h0020, 16'h0099, 1, 0, 16'h0020);
    add(0, 0, 6'h10, 2'b00, 16'h0020, 16'h0100, 1, 1, 16'h0042);
    add(0, 0, 6'h10, 2'b00, 16'h0020, 16'h0101, 1, 0, 16'h0020);
    // Edge coincident with RET: RET wins, edge lost.
    add(0, 1, 6'h00, 2'b00, 16'h0020, 16'h0055, 1, 1, 16'hF000);
    add(0, 0, 6'h00, 2'b00, 16'h0020, 16'h0056, 1, 0, 16'h0020);
    add(0, 1, 6'h10, 2'b00, 16'h0020, 16'h0057, 1, 1, 16'h0055);
    add(0, 1, 6'h00, 2'b00, 16'h0020, 16'h0058, 1, 0, 16'h0020);
    add(0, 0, 6'h00, 2'b00, 16'h0020, 16'h0059, 1, 0, 16'h0020);
    // Reset mid-ISR discards context.
    add(0, 1, 6'h00, 2'b00, 16'h0020, 16'h0077, 1, 1, 16'hF000);
    add(1, 0, 6'h10, 2'b00, 16'h0020, 16'h0078, 1, 0, 16'h0000);
    add(0, 0, 6'h10, 2'b00, 16'h0020, 16'h0079, 1, 0, 16'h0020);
    // Fresh interrupt after reset is accepted again.
    add(0, 1, 6'h1E, 2'b10, 16'h0020, 16'h0abc, 1, 1, 16'hF000);
    add(0, 0, 6'h10, 2'b00, 16'h0020, 16'h0abd, 1, 1, 16'h0abc);

    m_saved_pc   = 16'h0000;
    m_inside_isr = 1'b0;
    m_irq_last   = 1'b0;

    reset = 1; interrupt = 0; op = 0; flag_ex = 0; jmp_address_pm = 0; current_address = 0;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset           = vecs[i].rst;
      interrupt       = vecs[i].irq;
      op              = vecs[i].opc;
      flag_ex         = vecs[i].flg;
      jmp_address_pm  = vecs[i].pm;
      current_address = vecs[i].cur;

      // Model: what the PC must do this cycle.
      fresh_irq = vecs[i].irq && !m_irq_last && !m_inside_isr;
      if (vecs[i].rst) begin
        want_sel = 0; want_loc = 16'h0000;
      end else if (fresh_irq) begin
        want_sel = 1; want_loc = 16'hF000;
      end else if (vecs[i].opc == 6'h10 && m_inside_isr) begin
        want_sel = 1; want_loc = m_saved_pc;
      end else begin
        want_sel = branch_condition_met(vecs[i].opc, vecs[i].flg);
        want_loc = vecs[i].pm;
      end

      @(negedge clk);
      $display("vec%0d rst=%0b irq=%0b op=%h flg=%b pm=%h cur=%h -> sel=%0b loc=%h",
               i, reset, interrupt, op, flag_ex, jmp_address_pm, current_address,
               pc_mux_sel, jmp_loc);
      check1 ("sel_model", i, pc_mux_sel, want_sel);
      check16("loc_model", i, jmp_loc, want_loc);
      if (vecs[i].chk) begin
        check1 ("sel_literal", i, pc_mux_sel, vecs[i].e_sel);
        check16("loc_literal", i, jmp_loc, vecs[i].e_loc);
      end

      // Model: context carried into the next cycle.
      if (vecs[i].rst) begin
        m_saved_pc = 16'h0000; m_inside_isr = 0; m_irq_last = 0;
      end else begin
        if (fresh_irq) begin
          m_saved_pc = vecs[i].cur; m_inside_isr = 1;
        end else if (vecs[i].opc == 6'h10 && m_inside_isr) begin
          m_inside_isr = 0;
        end
        m_irq_last = vecs[i].irq;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
